// File: rtl/pacman_pkg.sv
// Shared types and helpers for the pacman sprite path: directions, animation
// states and the direction/frame to palette-select mapping.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        F1  = 2'd0,
        F2  = 2'd1,
        F3  = 2'd2,
        F2B = 2'd3
    } anim_state_t;

    localparam int NUM_PAC_SPRITES = 12;

    // Select presented while reset holds: facing left, mouth closed.
    localparam logic [3:0] SEL_RESET = 4'd3;

    // F2B reuses the half-open artwork of F2.
    function automatic logic [1:0] frame_of(anim_state_t s);
        return (s == F2B) ? 2'd1 : 2'(s);
    endfunction

    function automatic logic [3:0] sel_of(dir_t d, logic [1:0] frame);
        return 4'(d) * 4'd3 + 4'(frame);
    endfunction

endpackage

// File: rtl/pacman_sprite_fetch_if.sv
// Sprite ROM port: the fetch stage drives the address, the ROM answers one
// cycle later with the 1-bit pixel.
interface pacman_sprite_fetch_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_q;

    modport master (output rom_addr, input rom_q);
    modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/pacman_anim_seq.sv
// Per-video-frame direction latch and mouth animation sequencer; everything
// here moves only on frame_start so the select is stable across a frame.
module pacman_anim_seq
    import pacman_pkg::*;
#(
    parameter int ANIM_DIV = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       moving,
    input  logic [1:0] dir_req,
    input  logic       dir_valid,
    output dir_t       dir,
    output logic [1:0] frame
);

    localparam logic [3:0] CNT_LAST = 4'(ANIM_DIV - 1);

    anim_state_t state_reg, state_next;
    dir_t        dir_reg, dir_next;
    logic [3:0]  cnt_reg, cnt_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= F1;
            cnt_reg   <= '0;
            dir_reg   <= DIR_LEFT;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        if (frame_start) begin
            if (dir_valid) begin
                dir_next = dir_t'(dir_req);
            end
            // A stationary pacman freezes with the mouth closed.
            if (!moving) begin
                state_next = F1;
                cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
                case (state_reg)
                    F1:      state_next = F2;
                    F2:      state_next = F3;
                    F3:      state_next = F2B;
                    F2B:     state_next = F1;
                    default: state_next = F1;
                endcase
            end else begin
                cnt_next = cnt_reg + 4'd1;
            end
        end
    end

    assign dir   = dir_reg;
    assign frame = frame_of(state_reg);

endmodule

// File: rtl/pacman_sprite_fetch.sv
// Pacman sprite fetch: hit test and ROM address per pixel, then a fixed
// three-cycle pipeline returning hit, ROM index and the palette select.
module pacman_sprite_fetch
    import pacman_pkg::*;
#(
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int ANIM_DIV = 4,
    parameter int ADDR_W   = 12
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_start,
    input  logic                         moving,
    input  logic [1:0]                   dir_req,
    input  logic                         dir_valid,
    input  logic [9:0]                   pac_x,
    input  logic [9:0]                   pac_y,
    input  logic [9:0]                   draw_x,
    input  logic [9:0]                   draw_y,
    pacman_sprite_fetch_if.master        rom,
    output logic                         pixel_hit,
    output logic                         pixel_index,
    output logic [3:0]                   sprite_sel
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    dir_t       dir_cur;
    logic [1:0] frame_cur;
    logic [3:0] sel_cur;

    pacman_anim_seq #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_seq (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .moving      (moving),
        .dir_req     (dir_req),
        .dir_valid   (dir_valid),
        .dir         (dir_cur),
        .frame       (frame_cur)
    );

    assign sel_cur = sel_of(dir_cur, frame_cur);

    // Modulo offsets: pixels left of / above the sprite wrap large and miss.
    logic [9:0]        dx, dy;
    logic              hit;
    logic [ADDR_W-1:0] addr_next;

    assign dx  = draw_x - pac_x;
    assign dy  = draw_y - pac_y;
    assign hit = ({1'b0, dx} < 11'(SPR_W)) && ({1'b0, dy} < 11'(SPR_H));

    always_comb begin
        addr_next = '0;
        if (hit) begin
            addr_next = ADDR_W'(sel_cur) * ADDR_W'(SPR_W * SPR_H)
                      + ADDR_W'(dy[YB-1:0]) * ADDR_W'(SPR_W)
                      + ADDR_W'(dx[XB-1:0]);
        end
    end

    logic [ADDR_W-1:0] rom_addr_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_reg <= '0;
        end else begin
            rom_addr_reg <= addr_next;
        end
    end

    assign rom.rom_addr = rom_addr_reg;

    // Hit and select ride alongside the ROM access so a frame_start never
    // retags a pixel that is already in flight.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dly
        logic       hit_in;
        logic [3:0] sel_in;
        logic       hit_reg;
        logic [3:0] sel_reg;

        if (gi == 0) begin : g_head
            assign hit_in = hit;
            assign sel_in = sel_cur;
        end else begin : g_tail
            assign hit_in = g_dly[gi-1].hit_reg;
            assign sel_in = g_dly[gi-1].sel_reg;
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                hit_reg <= 1'b0;
                sel_reg <= SEL_RESET;
            end else begin
                hit_reg <= hit_in;
                sel_reg <= sel_in;
            end
        end
    end

    logic       pixel_hit_reg;
    logic       pixel_index_reg;
    logic [3:0] sprite_sel_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_hit_reg   <= 1'b0;
            pixel_index_reg <= 1'b0;
            sprite_sel_reg  <= SEL_RESET;
        end else begin
            pixel_hit_reg   <= g_dly[1].hit_reg;
            pixel_index_reg <= g_dly[1].hit_reg & rom.rom_q;
            sprite_sel_reg  <= g_dly[1].sel_reg;
        end
    end

    assign pixel_hit   = pixel_hit_reg;
    assign pixel_index = pixel_index_reg;
    assign sprite_sel  = sprite_sel_reg;

endmodule

// File: tb/tb_pacman_sprite_fetch.sv
// Scoreboarded bench for pacman_sprite_fetch: pixels push expected ROM address
// and outputs keyed by due cycle; a negedge monitor pops and compares them.
module tb_pacman_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       moving = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       dir_valid = 1'b0;
    logic [9:0] pac_x = 10'd100;
    logic [9:0] pac_y = 10'd50;
    logic [9:0] draw_x = 10'd0;
    logic [9:0] draw_y = 10'd0;
    logic       pixel_hit;
    logic       pixel_index;
    logic [3:0] sprite_sel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pacman_sprite_fetch_if #(.ADDR_W(12)) rom_bus ();

    pacman_sprite_fetch #(
        .SPR_W(16), .SPR_H(16), .ANIM_DIV(4), .ADDR_W(12)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .moving(moving),
        .dir_req(dir_req), .dir_valid(dir_valid),
        .pac_x(pac_x), .pac_y(pac_y), .draw_x(draw_x), .draw_y(draw_y),
        .rom(rom_bus.master),
        .pixel_hit(pixel_hit), .pixel_index(pixel_index), .sprite_sel(sprite_sel)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic rom_bit(input logic [11:0] a);
        if (a == 12'd0) return 1'b1;
        return a[0] ^ a[4] ^ a[8];
    endfunction

    always @(posedge Clk) rom_bus.rom_q <= rom_bit(rom_bus.rom_addr);

    // Reference animation model
    int m_dir = 1, m_st = 0, m_cnt = 0;

    function automatic int model_sel();
        int fr;
        fr = (m_st == 3) ? 1 : m_st;
        return m_dir * 3 + fr;
    endfunction

    task automatic model_pulse(input logic mov, input logic dv, input logic [1:0] dr);
        if (dv) m_dir = int'(dr);
        if (!mov) begin
            m_st = 0; m_cnt = 0;
        end else if (m_cnt == 3) begin
            m_cnt = 0; m_st = (m_st + 1) % 4;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    typedef struct { int due; logic [11:0] addr; int x; int y; } addr_t;
    typedef struct { int due; logic hit; logic idx; logic [3:0] sel; int x; int y; } out_t;
    addr_t addr_q[$];
    out_t  out_q[$];

    task automatic push_expect();
        logic [9:0] dx, dy;
        logic       h;
        int         a;
        addr_t      ea;
        out_t       eo;
        dx = draw_x - pac_x;
        dy = draw_y - pac_y;
        h  = (dx < 10'd16) && (dy < 10'd16);
        a  = h ? model_sel() * 256 + int'(dy[3:0]) * 16 + int'(dx[3:0]) : 0;
        ea.due = cyc + 1; ea.addr = 12'(a); ea.x = int'(draw_x); ea.y = int'(draw_y);
        eo.due = cyc + 3; eo.hit = h; eo.idx = h ? rom_bit(12'(a)) : 1'b0;
        eo.sel = 4'(model_sel()); eo.x = int'(draw_x); eo.y = int'(draw_y);
        addr_q.push_back(ea);
        out_q.push_back(eo);
    endtask

    always @(negedge Clk) begin
        addr_t ea;
        out_t  eo;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            ea = addr_q.pop_front();
            checks++;
            if (ea.due != cyc || rom_bus.rom_addr !== ea.addr) begin
                errors++;
                $display("FAIL rom_addr x=%0d y=%0d got %0d exp %0d", ea.x, ea.y, rom_bus.rom_addr, ea.addr);
            end
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            eo = out_q.pop_front();
            checks++;
            if (eo.due != cyc || pixel_hit !== eo.hit) begin
                errors++;
                $display("FAIL pixel_hit x=%0d y=%0d got %0b exp %0b", eo.x, eo.y, pixel_hit, eo.hit);
            end
            checks++;
            if (pixel_index !== eo.idx) begin
                errors++;
                $display("FAIL pixel_index x=%0d y=%0d got %0b exp %0b", eo.x, eo.y, pixel_index, eo.idx);
            end
            checks++;
            if (sprite_sel !== eo.sel) begin
                errors++;
                $display("FAIL sprite_sel x=%0d y=%0d got %0d exp %0d", eo.x, eo.y, sprite_sel, eo.sel);
            end
        end
    end

    task automatic px(input int x, input int y);
        @(negedge Clk);
        draw_x = 10'(x);
        draw_y = 10'(y);
        push_expect();
    endtask

    task automatic idle();
        @(negedge Clk);
        draw_x = pac_x - 10'd1;
        draw_y = pac_y;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_q.size() > 0 || addr_q.size() > 0) && n < 20) begin
            idle();
            n++;
        end
        checks++;
        if (out_q.size() > 0 || addr_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", out_q.size() + addr_q.size());
            addr_q.delete();
            out_q.delete();
        end
    endtask

    task automatic pulse(input logic mov, input logic dv, input logic [1:0] dr);
        @(negedge Clk);
        frame_start = 1'b1; moving = mov; dir_valid = dv; dir_req = dr;
        draw_x = pac_x - 10'd1; draw_y = pac_y;
        model_pulse(mov, dv, dr);
        @(negedge Clk);
        frame_start = 1'b0; dir_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (pixel_hit !== 1'b0 || pixel_index !== 1'b0 || sprite_sel !== 4'd3 || rom_bus.rom_addr !== 12'd0) begin
            errors++;
            $display("FAIL reset_state got hit=%0b idx=%0b sel=%0d addr=%0d exp 0 0 3 0",
                     pixel_hit, pixel_index, sprite_sel, rom_bus.rom_addr);
        end
        Reset = 1'b0;
        idle();
    endtask

    task automatic test_single_hit();
        pac_x = 10'd100; pac_y = 10'd50;
        px(100, 50);
        @(negedge Clk);
        checks++;
        if (rom_bus.rom_addr !== 12'd768) begin
            errors++;
            $display("FAIL first_addr got %0d exp 768", rom_bus.rom_addr);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if (pixel_hit !== 1'b1 || pixel_index !== 1'b1 || sprite_sel !== 4'd3) begin
            errors++;
            $display("FAIL first_pixel got hit=%0b idx=%0b sel=%0d exp 1 1 3", pixel_hit, pixel_index, sprite_sel);
        end
        drain();
    endtask

    task automatic test_scan();
        for (int x = 99; x <= 116; x++) px(x, 50);
        for (int y = 48; y <= 67; y += 3) px(107, y);
        drain();
    endtask

    task automatic test_anim();
        int exp_sel[16] = '{6, 6, 6, 7, 7, 7, 7, 8, 8, 8, 8, 7, 7, 7, 7, 6};
        for (int i = 0; i < 16; i++) begin
            pulse(1'b1, 1'b1, 2'd2);
            px(105, 55);
            drain();
            checks++;
            if (sprite_sel !== 4'(exp_sel[i])) begin
                errors++;
                $display("FAIL anim_sel pulse=%0d got %0d exp %0d", i + 1, sprite_sel, exp_sel[i]);
            end
        end
        pulse(1'b1, 1'b1, 2'd2);
        pulse(1'b1, 1'b1, 2'd2);
        pulse(1'b1, 1'b1, 2'd2);
        pulse(1'b0, 1'b0, 2'd0);
        px(101, 51);
        drain();
        checks++;
        if (sprite_sel !== 4'd6) begin
            errors++;
            $display("FAIL anim_freeze got %0d exp 6", sprite_sel);
        end
    endtask

    task automatic test_dir_change();
        @(negedge Clk);
        dir_req = 2'd3; dir_valid = 1'b1;
        px(102, 52);
        px(103, 53);
        drain();
        dir_valid = 1'b0;
        checks++;
        if (sprite_sel !== 4'd6) begin
            errors++;
            $display("FAIL dir_midframe got %0d exp 6", sprite_sel);
        end
        pulse(1'b1, 1'b1, 2'd3);
        px(104, 54);
        drain();
        checks++;
        if (sprite_sel !== 4'd9) begin
            errors++;
            $display("FAIL dir_latched got %0d exp 9", sprite_sel);
        end
        pulse(1'b1, 1'b0, 2'd0);
        px(104, 54);
        drain();
        checks++;
        if (sprite_sel !== 4'd9) begin
            errors++;
            $display("FAIL dir_held got %0d exp 9", sprite_sel);
        end
    endtask

    task automatic test_reset_inflight();
        pulse(1'b1, 1'b1, 2'd0);
        pulse(1'b1, 1'b1, 2'd0);
        @(negedge Clk);
        draw_x = 10'd105; draw_y = 10'd52;
        @(negedge Clk);
        draw_x = 10'd99;  draw_y = 10'd50;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_dir = 1; m_st = 0; m_cnt = 0;
        checks++;
        if (pixel_hit !== 1'b0 || sprite_sel !== 4'd3 || rom_bus.rom_addr !== 12'd0 || pixel_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight got hit=%0b sel=%0d addr=%0d exp 0 3 0",
                     pixel_hit, sprite_sel, rom_bus.rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++;
            if (pixel_hit !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale cycle=%0d got %0b exp 0", i, pixel_hit);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0, 2'd0);
            px(108, 58);
            drain();
            checks++;
            if (sprite_sel !== ((i < 3) ? 4'd3 : 4'd4)) begin
                errors++;
                $display("FAIL reset_fsm pulse=%0d got %0d exp %0d", i + 1, sprite_sel, (i < 3) ? 3 : 4);
            end
        end
    endtask

    task automatic test_edge();
        @(negedge Clk);
        pac_x = 10'd1008; pac_y = 10'd200;
        px(1023, 215);
        px(5, 215);
        px(1008, 200);
        px(1007, 200);
        px(1015, 216);
        drain();
    endtask

    task automatic test_back_to_back();
        pac_x = 10'd300; pac_y = 10'd120;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            frame_start = (i % 7 == 3);
            moving      = (i % 13 != 9);
            dir_valid   = (i % 5 == 0);
            dir_req     = 2'($urandom_range(0, 3));
            draw_x      = 10'(298 + $urandom_range(0, 20));
            draw_y      = 10'(118 + $urandom_range(0, 20));
            push_expect();
            if (frame_start) model_pulse(moving, dir_valid, dir_req);
        end
        @(negedge Clk);
        frame_start = 1'b0; dir_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_scan();
        test_anim();
        test_dir_change();
        test_reset_inflight();
        test_edge();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pacman_sprite_fetch.md
Name: pacman_sprite_fetch

Overview:
- Upstream stage of the pacman sprite palettes.
- Per VGA pixel: decides whether the pixel lies inside the pacman sprite and forms the sprite-ROM address from the latched direction and animation frame.
- Returns the 1-bit ROM index together with the sprite select. The downstream palette mux uses the select to choose among the 12 direction/frame palettes, whose index polarity differs per sprite.
- Also owns the per-frame animation sequencer and direction latch.

Parameters:
- SPR_W, 16, sprite width in pixels (power of 2)
- SPR_H, 16, sprite height in pixels (power of 2)
- ANIM_DIV, 4, video frames per animation step (1..15)
- ADDR_W, 12, ROM address width; must be >= clog2(12*SPR_W*SPR_H)

Ports:
- Clk  in  1  pixel clock; only clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- moving  in  1  pacman moved this frame; sampled at frame_start
- dir_req  in  2  requested direction: 0 = down, 1 = left, 2 = right, 3 = up
- dir_valid  in  1  dir_req is meaningful; sampled at frame_start
- pac_x  in  10  sprite top-left X
- pac_y  in  10  sprite top-left Y
- draw_x  in  10  current pixel X
- draw_y  in  10  current pixel Y
- rom_addr  out  ADDR_W  registered address to the sprite ROM
- rom_q  in  1  ROM data; valid exactly 1 cycle after rom_addr
- pixel_hit  out  1  pixel lies inside the sprite (aligned with pixel_index)
- pixel_index  out  1  palette index for the pixel; 0 when pixel_hit = 0
- sprite_sel  out  4  dir*3 + frame (0..11) for the palette mux

Behaviour:
- Reset (synchronous, Reset = 1 at a Clk edge):
  - dir = left (1), frame state = F1, anim counter = 0.
  - rom_addr = 0, pixel_hit = 0, pixel_index = 0, sprite_sel = 3.
  - All pipeline valid/hit bits cleared. An in-flight pixel is discarded; no stale hit appears after reset.
- Direction latch:
  - At frame_start with dir_valid = 1, dir <= dir_req.
  - Otherwise dir holds.
  - Never changes mid-frame.
- Animation FSM: states F1(0), F2(1), F3(2), F2B(1); frame value in parentheses.
  - Updates only on frame_start.
  - If moving = 0: state <= F1 and counter <= 0 (mouth-closed freeze).
  - Else counter increments. When counter == ANIM_DIV-1, counter <= 0 and state advances F1 -> F2 -> F3 -> F2B -> F1.
  - frame_start coinciding with a dir change: both updates take effect in the same cycle.
- sprite_sel_cur = dir*3 + frame, 4-bit unsigned; it is stable within a frame.
- Hit test (cycle T, combinational, registered at T+1):
  - dx = draw_x - pac_x, dy = draw_y - pac_y, each 10-bit modulo.
  - hit = (dx < SPR_W) && (dy < SPR_H).
  - Pixels left of or above the sprite wrap to large values and miss.
  - A sprite at the screen edge (pac_x = 1023 - SPR_W + 1) must still hit its last column.
- Pipeline:
  - T+1: rom_addr <= sel*SPR_W*SPR_H + dy[log2 SPR_H-1:0]*SPR_W + dx[log2 SPR_W-1:0], truncated to ADDR_W. If hit = 0, rom_addr <= 0. hit and sel are delayed with it.
  - T+2: rom_q valid; hit and sel delayed again.
  - T+3: pixel_hit <= hit_d2, pixel_index <= hit_d2 ? rom_q : 0, sprite_sel <= sel_d2.
- Fixed latency: 3 cycles from draw_x/draw_y to outputs, independent of hit. There is no back-pressure.
- sprite_sel travels with the pixel. A frame_start in flight does not retag pixels already in the pipeline.

Decomposition:
- Shared package (pacman_pkg):
  - dir_t enum {DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_UP}
  - anim_state_t enum {F1, F2, F3, F2B}
  - NUM_PAC_SPRITES = 12
  - function sel_of(dir, frame)
- Sub-module pacman_anim_seq: the direction latch plus the animation FSM and counter. Outputs dir and frame.
- The top level holds the hit test and the 3-stage pipeline.

Test Plan:
- Reset, then pac_x = 100, pac_y = 50, draw_x/draw_y = 100/50 at cycle 0, ROM model returns 1 for addr 768 (sel 3, offset 0):
  - rom_addr = 768 at cycle 1.
  - pixel_hit = 1, pixel_index = 1, sprite_sel = 3 at cycle 3.
- Scan draw_x 99..116 at draw_y = 50 with pac_x = 100:
  - pixel_hit = 1 for 100..115, 0 for 99 and 116.
  - pixel_index = 0 on misses even when rom_q = 1.
- moving = 1, ANIM_DIV = 4, dir_valid = 1, dir_req = 2, 16 frame_start pulses:
  - sprite_sel steps 6, 7, 8, 7, 6, changing every 4th frame.
  - moving = 0 at the next pulse forces sprite_sel = 6.
- dir_req changes to 3 mid-frame with dir_valid = 1:
  - sprite_sel unchanged until the next frame_start, then 9 + frame.
  - With dir_valid = 0 at frame_start, dir is held.
- Assert Reset while a hit pixel is in stage 2:
  - Next cycles show pixel_hit = 0, sprite_sel = 3, rom_addr = 0.
  - FSM returns to F1 with the counter cleared.
- Edge case pac_x = 1008, draw_x = 1023, draw_y = pac_y + 15:
  - Hit; rom_addr = sel*256 + 15*16 + 15.
  - draw_x = 5 with pac_x = 1008 is a miss (no wrap-around hit).
